nq_exec_unit: RTL and testbench
===============================

NQ_EXEC_UNIT -- requirements
Module: nq_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  async active-high reset.
REQ-004 fetch_ready  in  1  fetch stage holds a valid instruction.
REQ-005 fetch_en, decode_en, alu_en, incr_pc  out  1 each  stage enables and PC+2 strobe.
REQ-006 dbg_state  out  10  one-hot sequencer state.
REQ-007 ctrl_in  in  33  control word; imm_in in 16; pc_in in 16  from decoder.
REQ-008 rf_regA, rf_regB, rf_regDest  out  3; rf_dataIn out 16; rf_we, rf_hb, rf_lb out 1; rf_dataA, rf_dataB in 16  register-file port.
REQ-009 memData_in  in  16  memory read data; memData_out  out  16  store data, always rf_dataB.
REQ-010 ctrl_out out 33, imm_out out 16, pc_out out 16  registered stage outputs.
REQ-011 branch_taken  out  1; branch_target  out  16  PC redirect.
REQ-012 Decoded fields of ctrl_out: aluOp 4, aluReg1 3, aluReg2 3, aluOpSource1 2, aluOpSource2 2, aluDest 1, regDest 3, regSetH 1, regSetL 1, regAddr 3, memReadB/memReadW/memWriteB/memWriteW 1 each, setRegCond 6, all outputs.

Function
REQ-013 Control word layout, MSB first: aluOp[32:29], aluReg1[28:26], aluReg2[25:23], src1[22:21], src2[20:19], aluDest[18], regDest[17:15], regSetH[14], regSetL[13], regAddr[12:10], memReadB[9], memReadW[8], memWriteB[7], memWriteW[6], setRegCond[5:0].
REQ-014 Decode of any 33-bit word SHALL be purely combinational field slicing.
REQ-015 Sequencer states: FETCH (dbg_state=bit0), DECODE (bit1), EXEC (bit2); bits 9:3 always 0.
REQ-016 FETCH: fetch_en=1; moves to DECODE on the edge where fetch_ready=1, else stays.
REQ-017 DECODE: decode_en=1, incr_pc=1 for exactly one cycle; then EXEC.
REQ-018 EXEC: alu_en=1 for exactly one cycle; then FETCH.
REQ-019 At most one of fetch_en/decode_en/alu_en SHALL be high in any cycle.
REQ-020 rf_regA=ctrl_in.aluReg1, rf_regB=ctrl_in.aluReg2, combinational.
REQ-021 Operand A: src1 0=rf_dataA, 1=memData_in, 2=imm_in, 3=pc_in.
REQ-022 Operand B: src2 0=rf_dataB, 1=~rf_dataB, 2=pc_in, 3=imm_in.
REQ-023 aluOp: 0 A+B, 1 A-B, 2 A&B, 3 A|B, 4 A^B, 5 ~A, 6 A<<1, 7 A>>1 logical, 8 A>>>1 arithmetic, 9 A, 10 B, 11 byte-swap A, 12 zero-extend A[7:0], 13 sign-extend A[7:0], 14 A+B+1, 15 B; 16-bit results, carries discarded, wrap-around mod 2^16.
REQ-024 Flags Z=(result==0), S=result[15]; updated on every edge with alu_en=1 and held otherwise.
REQ-025 Write condition cond: setRegCond[5]=0 -> true; else match=(bit3|Z==bit1)&(bit2|S==bit0), with Z and S being the flags held before the current EXEC; cond=match when bit4=1, !match when bit4=0.
REQ-026 rf_we = alu_en & cond & ~aluDest & (regSetH|regSetL); rf_regDest=regDest, rf_hb=regSetH, rf_lb=regSetL, rf_dataIn=result, all from ctrl_in.
REQ-027 branch_taken = alu_en & cond & aluDest; branch_target=result; combinational.
REQ-028 On alu_en edge: ctrl_out<=ctrl_in, imm_out<=imm_in, pc_out<=pc_in; otherwise hold.
REQ-029 Input changes outside EXEC SHALL NOT alter registered state.

Reset
REQ-030 reset asserted SHALL immediately force FETCH (dbg_state=10'h001), ctrl_out=0, imm_out=0, pc_out=0, Z=0, S=0.
REQ-031 Reset mid-DECODE/EXEC SHALL abort with no rf_we and no branch; release resumes at FETCH.

Verification
REQ-032 Reset, fetch_ready=0 for 5 cycles -> fetch_en=1, dbg_state=001 throughout; then fetch_ready=1 -> DECODE (002) with incr_pc=1, then EXEC (004) with alu_en=1, then 001.
REQ-033 aluOp=0, src1=0, src2=0, rf_dataA=16'hFFFF, rf_dataB=1, regSetH=regSetL=1, regDest=3, setRegCond=0 -> rf_we=1 in EXEC, rf_dataIn=0, rf_regDest=3; next cycle Z=1.
REQ-034 aluOp=1, src2=3, imm_in=5, rf_dataA=3 -> result 16'hFFFE, S=1.
REQ-035 Z=1 held, setRegCond=6'b110110 (enabled, true-polarity, S don't-care, Z must be 1), aluDest=1, src1=3, src2=3, aluOp=0, pc_in=16'h0100, imm_in=16'h0010 -> branch_taken=1, branch_target=16'h0110; with Z=0 -> branch_taken=0.
REQ-036 ctrl_in=33'h1_2345_6789 through EXEC -> ctrl_out equals it; decoded aluOp=4'h9, setRegCond=6'h09, others sliced per REQ-013.

Source files
------------

// File: rtl/nq_exec_unit.sv
// nq_exec_unit: three-state fetch/decode/exec sequencer with a 16-bit ALU.
// Condition flags are held across instructions and gate register-file
// writebacks and PC redirects. The instruction's control word, immediate
// and PC are latched as stage outputs when it executes.
module nq_exec_unit (
  input  logic        clk,
  input  logic        reset,
  // sequencer
  input  logic        fetch_ready,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        alu_en,
  output logic        incr_pc,
  output logic [9:0]  dbg_state,
  // from decoder
  input  logic [32:0] ctrl_in,
  input  logic [15:0] imm_in,
  input  logic [15:0] pc_in,
  // register file port
  output logic [2:0]  rf_regA,
  output logic [2:0]  rf_regB,
  output logic [2:0]  rf_regDest,
  output logic [15:0] rf_dataIn,
  output logic        rf_we,
  output logic        rf_hb,
  output logic        rf_lb,
  input  logic [15:0] rf_dataA,
  input  logic [15:0] rf_dataB,
  // memory
  input  logic [15:0] memData_in,
  output logic [15:0] memData_out,
  // registered stage outputs
  output logic [32:0] ctrl_out,
  output logic [15:0] imm_out,
  output logic [15:0] pc_out,
  // PC redirect
  output logic        branch_taken,
  output logic [15:0] branch_target,
  // decoded fields of ctrl_out
  output logic [3:0]  aluOp,
  output logic [2:0]  aluReg1,
  output logic [2:0]  aluReg2,
  output logic [1:0]  aluOpSource1,
  output logic [1:0]  aluOpSource2,
  output logic        aluDest,
  output logic [2:0]  regDest,
  output logic        regSetH,
  output logic        regSetL,
  output logic [2:0]  regAddr,
  output logic        memReadB,
  output logic        memReadW,
  output logic        memWriteB,
  output logic        memWriteW,
  output logic [5:0]  setRegCond
);

  // One-hot encoding, so the state register doubles as the debug view.
  typedef enum logic [2:0] {
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b100
  } state_t;

  state_t      state_q;
  logic        z_q, s_q;
  logic [32:0] ctrl_q;
  logic [15:0] imm_q, pc_q;

  // Fields of the incoming control word that drive the current EXEC.
  logic [3:0]  op_w;
  logic [1:0]  src1_w, src2_w;
  logic        dest_w, seth_w, setl_w;
  logic [5:0]  cond_w;
  logic [15:0] opa, opb, result;
  logic        match, cond;

  assign op_w   = ctrl_in[32:29];
  assign src1_w = ctrl_in[22:21];
  assign src2_w = ctrl_in[20:19];
  assign dest_w = ctrl_in[18];
  assign seth_w = ctrl_in[14];
  assign setl_w = ctrl_in[13];
  assign cond_w = ctrl_in[5:0];

  // Sequencer: FETCH waits for an instruction, DECODE and EXEC last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else begin
      case (state_q)
        S_FETCH:  if (fetch_ready) state_q <= S_DECODE;
        S_DECODE: state_q <= S_EXEC;
        S_EXEC:   state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign fetch_en  = state_q[0];
  assign decode_en = state_q[1];
  assign incr_pc   = state_q[1];
  assign alu_en    = state_q[2];
  assign dbg_state = {7'b0, state_q};

  // Operand selection and ALU.
  always_comb begin
    opa = rf_dataA;
    case (src1_w)
      2'd0: opa = rf_dataA;
      2'd1: opa = memData_in;
      2'd2: opa = imm_in;
      2'd3: opa = pc_in;
      default: opa = rf_dataA;
    endcase
    opb = rf_dataB;
    case (src2_w)
      2'd0: opb = rf_dataB;
      2'd1: opb = ~rf_dataB;
      2'd2: opb = pc_in;
      2'd3: opb = imm_in;
      default: opb = rf_dataB;
    endcase
    result = '0;
    case (op_w)
      4'd0:  result = opa + opb;
      4'd1:  result = opa - opb;
      4'd2:  result = opa & opb;
      4'd3:  result = opa | opb;
      4'd4:  result = opa ^ opb;
      4'd5:  result = ~opa;
      4'd6:  result = {opa[14:0], 1'b0};
      4'd7:  result = {1'b0, opa[15:1]};
      4'd8:  result = {opa[15], opa[15:1]};
      4'd9:  result = opa;
      4'd10: result = opb;
      4'd11: result = {opa[7:0], opa[15:8]};
      4'd12: result = {8'h00, opa[7:0]};
      4'd13: result = {{8{opa[7]}}, opa[7:0]};
      4'd14: result = opa + opb + 16'd1;
      4'd15: result = opb;
      default: result = '0;
    endcase
  end

  // Condition uses the flags left by the previous instruction; bit3/bit2
  // mark Z/S as don't-care and bit4 selects true or inverted polarity.
  assign match = (cond_w[3] | (z_q == cond_w[1])) & (cond_w[2] | (s_q == cond_w[0]));
  assign cond  = ~cond_w[5] | (cond_w[4] ? match : ~match);

  assign rf_regA       = ctrl_in[28:26];
  assign rf_regB       = ctrl_in[25:23];
  assign rf_regDest    = ctrl_in[17:15];
  assign rf_hb         = seth_w;
  assign rf_lb         = setl_w;
  assign rf_dataIn     = result;
  assign rf_we         = alu_en & cond & ~dest_w & (seth_w | setl_w);
  assign branch_taken  = alu_en & cond & dest_w;
  assign branch_target = result;
  assign memData_out   = rf_dataB;

  // Flags and stage registers only move when an instruction executes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q    <= 1'b0;
      s_q    <= 1'b0;
      ctrl_q <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
    end else if (alu_en) begin
      z_q    <= (result == 16'h0000);
      s_q    <= result[15];
      ctrl_q <= ctrl_in;
      imm_q  <= imm_in;
      pc_q   <= pc_in;
    end
  end

  assign ctrl_out     = ctrl_q;
  assign imm_out      = imm_q;
  assign pc_out       = pc_q;
  assign aluOp        = ctrl_q[32:29];
  assign aluReg1      = ctrl_q[28:26];
  assign aluReg2      = ctrl_q[25:23];
  assign aluOpSource1 = ctrl_q[22:21];
  assign aluOpSource2 = ctrl_q[20:19];
  assign aluDest      = ctrl_q[18];
  assign regDest      = ctrl_q[17:15];
  assign regSetH      = ctrl_q[14];
  assign regSetL      = ctrl_q[13];
  assign regAddr      = ctrl_q[12:10];
  assign memReadB     = ctrl_q[9];
  assign memReadW     = ctrl_q[8];
  assign memWriteB    = ctrl_q[7];
  assign memWriteW    = ctrl_q[6];
  assign setRegCond   = ctrl_q[5:0];

endmodule

// File: tb/tb_nq_exec_unit.sv
// Directed bench for nq_exec_unit: an ALU vector table plus hand-written
// sequences for the sequencer, flag-conditioned writes/branches, stage
// registers and reset abort.
module tb_nq_exec_unit;

  logic        clk = 1'b0;
  logic        reset, fetch_ready;
  logic        fetch_en, decode_en, alu_en, incr_pc;
  logic [9:0]  dbg_state;
  logic [32:0] ctrl_in;
  logic [15:0] imm_in, pc_in;
  logic [2:0]  rf_regA, rf_regB, rf_regDest;
  logic [15:0] rf_dataIn;
  logic        rf_we, rf_hb, rf_lb;
  logic [15:0] rf_dataA, rf_dataB, memData_in, memData_out;
  logic [32:0] ctrl_out;
  logic [15:0] imm_out, pc_out;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [3:0]  aluOp;
  logic [2:0]  aluReg1, aluReg2, regDest, regAddr;
  logic [1:0]  aluOpSource1, aluOpSource2;
  logic        aluDest, regSetH, regSetL, memReadB, memReadW, memWriteB, memWriteW;
  logic [5:0]  setRegCond;

  always #5 clk = ~clk;

  nq_exec_unit dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
    .fetch_en(fetch_en), .decode_en(decode_en), .alu_en(alu_en), .incr_pc(incr_pc),
    .dbg_state(dbg_state), .ctrl_in(ctrl_in), .imm_in(imm_in), .pc_in(pc_in),
    .rf_regA(rf_regA), .rf_regB(rf_regB), .rf_regDest(rf_regDest),
    .rf_dataIn(rf_dataIn), .rf_we(rf_we), .rf_hb(rf_hb), .rf_lb(rf_lb),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .memData_in(memData_in), .memData_out(memData_out),
    .ctrl_out(ctrl_out), .imm_out(imm_out), .pc_out(pc_out),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .aluOp(aluOp), .aluReg1(aluReg1), .aluReg2(aluReg2),
    .aluOpSource1(aluOpSource1), .aluOpSource2(aluOpSource2),
    .aluDest(aluDest), .regDest(regDest), .regSetH(regSetH), .regSetL(regSetL),
    .regAddr(regAddr), .memReadB(memReadB), .memReadW(memReadW),
    .memWriteB(memWriteB), .memWriteW(memWriteW), .setRegCond(setRegCond)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Control word builder, fields MSB first.
  function automatic logic [32:0] mk(input logic [3:0] op, input logic [2:0] r1, input logic [2:0] r2,
                                     input logic [1:0] s1, input logic [1:0] s2, input logic dst,
                                     input logic [2:0] rd, input logic h, input logic l,
                                     input logic [5:0] cnd);
    return {op, r1, r2, s1, s2, dst, rd, h, l, 3'd0, 4'd0, cnd};
  endfunction

  task automatic set_in(input logic [32:0] c, input logic [15:0] imm, input logic [15:0] pc,
                        input logic [15:0] da, input logic [15:0] db, input logic [15:0] mem);
    ctrl_in = c; imm_in = imm; pc_in = pc; rf_dataA = da; rf_dataB = db; memData_in = mem;
  endtask

  // From a FETCH negedge, advance to the EXEC cycle of the loaded instruction.
  task automatic go_exec(input string nm);
    fetch_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_decode"}, {dbg_state, decode_en, incr_pc, fetch_en, alu_en}, {10'h002, 4'b1100});
    fetch_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_exec"}, {dbg_state, alu_en, decode_en}, {10'h004, 2'b10});
  endtask

  typedef struct {
    logic [32:0] ctrl;
    logic [15:0] imm, pc, da, db, mem;
    logic        we;
    logic [15:0] res;
    logic        br;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // Common operands: A=1234, B=00F0, imm=8081, pc=0200, mem=A55A.
    tbl[0]  = '{mk(4'd0, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h1324, 0};
    tbl[1]  = '{mk(4'd1, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h1144, 0};
    tbl[2]  = '{mk(4'd2, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h0030, 0};
    tbl[3]  = '{mk(4'd3, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h12F4, 0};
    tbl[4]  = '{mk(4'd4, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h12C4, 0};
    tbl[5]  = '{mk(4'd5, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'hEDCB, 0};
    tbl[6]  = '{mk(4'd6, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h2468, 0};
    tbl[7]  = '{mk(4'd7, 1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h091A, 0};
    tbl[8]  = '{mk(4'd8, 1,2,1,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'hD2AD, 0};
    tbl[9]  = '{mk(4'd9, 1,2,2,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h8081, 0};
    tbl[10] = '{mk(4'd10,1,2,0,1,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'hFF0F, 0};
    tbl[11] = '{mk(4'd11,1,2,0,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h3412, 0};
    tbl[12] = '{mk(4'd12,1,2,2,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h0081, 0};
    tbl[13] = '{mk(4'd13,1,2,2,0,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'hFF81, 0};
    tbl[14] = '{mk(4'd14,1,2,3,3,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h8282, 0};
    tbl[15] = '{mk(4'd15,1,2,0,2,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h0200, 0};
    tbl[16] = '{mk(4'd0, 1,2,0,1,0,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h1143, 0};
    tbl[17] = '{mk(4'd0, 1,2,0,0,0,3,0,0,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 0, 16'h1324, 0};
    tbl[18] = '{mk(4'd9, 1,2,3,0,1,3,1,1,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 0, 16'h0200, 1};
    tbl[19] = '{mk(4'd3, 1,2,0,0,0,3,1,0,0), 16'h8081,16'h0200,16'h1234,16'h00F0,16'hA55A, 1, 16'h12F4, 0};

    reset = 1'b1; fetch_ready = 1'b0;
    set_in('0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("reset_state", {dbg_state, fetch_en, decode_en, alu_en}, {10'h001, 3'b100});
    chk("reset_regs", {ctrl_out[15:0], imm_out, pc_out}, 48'h0);
    reset = 1'b0;

    // Idle in FETCH, then one add that wraps to zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), {dbg_state, fetch_en}, {10'h001, 1'b1});
    end
    set_in(mk(4'd0, 3'd5, 3'd6, 0, 0, 0, 3'd3, 1, 1, 6'd0), 16'h0, 16'h0, 16'hFFFF, 16'h0001, 16'h0);
    go_exec("wrap");
    chk("wrap_we", rf_we, 1'b1);
    chk("wrap_data", rf_dataIn, 16'h0000);
    chk("wrap_ports", {rf_regDest, rf_regA, rf_regB, rf_hb, rf_lb}, {3'd3, 3'd5, 3'd6, 2'b11});
    chk("mem_out", memData_out, 16'h0001);
    @(negedge clk);
    chk("back_fetch", {dbg_state, alu_en, rf_we}, {10'h001, 2'b00});

    // Z=1 left by the wrap: Z-conditioned branch taken, its nonzero result clears Z.
    set_in(mk(4'd0, 0, 0, 3, 3, 1, 0, 0, 0, 6'b110110), 16'h0010, 16'h0100, 16'h0, 16'h0, 16'h0);
    go_exec("brz1");
    chk("brz1_taken", {branch_taken, rf_we}, 2'b10);
    chk("brz1_target", branch_target, 16'h0110);
    @(negedge clk);
    go_exec("brz0");
    chk("brz0_taken", branch_taken, 1'b0);
    @(negedge clk);

    // Subtract to negative sets S, then S-conditioned branches.
    set_in(mk(4'd1, 0, 0, 0, 3, 0, 3'd2, 1, 1, 6'd0), 16'h0005, 16'h0, 16'h0003, 16'h0, 16'h0);
    go_exec("sub");
    chk("sub_res", {rf_we, rf_dataIn}, {1'b1, 16'hFFFE});
    @(negedge clk);
    set_in(mk(4'd0, 0, 0, 3, 3, 1, 0, 0, 0, 6'b111001), 16'h0010, 16'h0100, 16'h0, 16'h0, 16'h0);
    go_exec("brs1");
    chk("brs1_taken", branch_taken, 1'b1);
    @(negedge clk);
    go_exec("brs0");
    chk("brs0_taken", branch_taken, 1'b0);
    @(negedge clk);
    set_in(mk(4'd0, 0, 0, 3, 3, 1, 0, 0, 0, 6'b101001), 16'h0010, 16'h0100, 16'h0, 16'h0, 16'h0);
    go_exec("brinv");
    chk("brinv_taken", branch_taken, 1'b1);
    @(negedge clk);
    set_in(mk(4'd0, 0, 0, 3, 3, 0, 1, 1, 1, 6'b111001), 16'h0010, 16'h0100, 16'h0, 16'h0, 16'h0);
    go_exec("condwe");
    chk("condwe_we", rf_we, 1'b0);
    @(negedge clk);

    // ALU vector table (unconditional writes, flags irrelevant).
    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].ctrl, tbl[i].imm, tbl[i].pc, tbl[i].da, tbl[i].db, tbl[i].mem);
      go_exec($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_res", i), rf_dataIn, tbl[i].res);
      chk($sformatf("vec%0d_we", i), rf_we, tbl[i].we);
      chk($sformatf("vec%0d_br", i), branch_taken, tbl[i].br);
      @(negedge clk);
    end

    // Stage registers and decoded fields.
    set_in(33'h1_2345_6789, 16'hBEEF, 16'hCAFE, 16'h0, 16'h0, 16'h0);
    go_exec("stage");
    @(negedge clk);
    chk("ctrl_out", ctrl_out, 33'h1_2345_6789);
    chk("imm_pc_out", {imm_out, pc_out}, 32'hBEEF_CAFE);
    chk("fld_op_regs", {aluOp, aluReg1, aluReg2}, {4'h9, 3'd0, 3'd6});
    chk("fld_src_dest", {aluOpSource1, aluOpSource2, aluDest, regDest}, {2'd2, 2'd0, 1'b1, 3'd2});
    chk("fld_set_addr", {regSetH, regSetL, regAddr}, {2'b11, 3'd1});
    chk("fld_mem_cond", {memReadB, memReadW, memWriteB, memWriteW, setRegCond}, {4'b1110, 6'h09});
    set_in(33'h0_AAAA_5555, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_ctrl", ctrl_out, 33'h1_2345_6789);
    chk("hold_imm_pc", {imm_out, pc_out}, 32'hBEEF_CAFE);

    // Reset during EXEC of a branch aborts it at once.
    set_in(mk(4'd9, 0, 0, 3, 0, 1, 0, 1, 1, 6'd0), 16'h0, 16'h4444, 16'h0, 16'h0, 16'h0);
    go_exec("abort");
    chk("abort_pre", branch_taken, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_now", {dbg_state, branch_taken, rf_we, alu_en}, {10'h001, 3'b000});
    chk("abort_regs", {ctrl_out, pc_out}, 49'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_resume", {dbg_state, fetch_en}, {10'h001, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
